// File: rtl/mandelbrot_pixel_sequencer_if.sv
// Handshake bundle between the pixel sequencer, the Mandelbrot engine,
// the framebuffer writer and the frame start/abort control.
interface mandelbrot_pixel_sequencer_if #(
   parameter int ITER_W = 6
);
   logic              start;
   logic              abort;
   logic [9:0]        pixel_x;
   logic [9:0]        pixel_y;
   logic              pixel_valid;
   logic              result_valid;
   logic              busy;
   logic [ITER_W-1:0] iteration_count;
   logic              wr_en;
   logic              wr_ready;
   logic [9:0]        wr_x;
   logic [9:0]        wr_y;
   logic [ITER_W-1:0] wr_data;
   logic              frame_busy;
   logic              frame_done;
   logic [18:0]       pixels_done;

   modport master (
      input  start, abort, result_valid, busy, iteration_count, wr_ready,
      output pixel_x, pixel_y, pixel_valid, wr_en, wr_x, wr_y, wr_data,
             frame_busy, frame_done, pixels_done
   );

   modport slave (
      output start, abort, result_valid, busy, iteration_count, wr_ready,
      input  pixel_x, pixel_y, pixel_valid, wr_en, wr_x, wr_y, wr_data,
             frame_busy, frame_done, pixels_done
   );
endinterface

// File: rtl/mandelbrot_pixel_sequencer.sv
// Raster-order pixel scheduler: feeds one pixel at a time to the engine and
// forwards each iteration count as a coordinate-tagged framebuffer write.
module mandelbrot_pixel_sequencer #(
   parameter int H_PIXELS = 640,
   parameter int V_PIXELS = 480,
   parameter int ITER_W   = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   mandelbrot_pixel_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_RESULT,
      S_WRITE,
      S_RELEASE,
      S_FLUSH
   } state_t;

   localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
   localparam logic [9:0] Y_LAST = 10'(V_PIXELS - 1);

   state_t            r_state,       w_state_nxt;
   logic [9:0]        r_pixel_x,     w_pixel_x_nxt;
   logic [9:0]        r_pixel_y,     w_pixel_y_nxt;
   logic              r_pixel_valid, w_pixel_valid_nxt;
   logic              r_wr_en,       w_wr_en_nxt;
   logic [9:0]        r_wr_x,        w_wr_x_nxt;
   logic [9:0]        r_wr_y,        w_wr_y_nxt;
   logic [ITER_W-1:0] r_wr_data,     w_wr_data_nxt;
   logic              r_frame_busy,  w_frame_busy_nxt;
   logic              r_frame_done,  w_frame_done_nxt;
   logic [18:0]       r_pixels_done, w_pixels_done_nxt;
   logic              w_last_pixel;

   assign w_last_pixel = (r_pixel_x == X_LAST) && (r_pixel_y == Y_LAST);

   // NOTE: every signal written here gets its hold value first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt       = r_state;
      w_pixel_x_nxt     = r_pixel_x;
      w_pixel_y_nxt     = r_pixel_y;
      w_pixel_valid_nxt = r_pixel_valid;
      w_wr_en_nxt       = r_wr_en;
      w_wr_x_nxt        = r_wr_x;
      w_wr_y_nxt        = r_wr_y;
      w_wr_data_nxt     = r_wr_data;
      w_frame_busy_nxt  = r_frame_busy;
      w_frame_done_nxt  = 1'b0;
      w_pixels_done_nxt = r_pixels_done;

      case (r_state)
         S_IDLE: begin
            // abort beats a simultaneous start
            if (bus.start && !bus.abort) begin
               w_pixel_x_nxt     = '0;
               w_pixel_y_nxt     = '0;
               w_pixel_valid_nxt = 1'b1;
               w_pixels_done_nxt = '0;
               w_frame_busy_nxt  = 1'b1;
               w_state_nxt       = S_WAIT_RESULT;
            end
         end

         S_WAIT_RESULT: begin
            if (bus.abort) begin
               w_pixel_valid_nxt = 1'b0;
               w_wr_en_nxt       = 1'b0;
               w_state_nxt       = S_FLUSH;
            end else if (bus.result_valid) begin
               w_wr_data_nxt     = bus.iteration_count;
               w_wr_x_nxt        = r_pixel_x;
               w_wr_y_nxt        = r_pixel_y;
               w_wr_en_nxt       = 1'b1;
               w_pixel_valid_nxt = 1'b0;
               w_state_nxt       = S_WRITE;
            end
         end

         S_WRITE: begin
            if (bus.wr_ready) begin
               // an accepted write is counted even if abort arrives with it
               w_wr_en_nxt       = 1'b0;
               w_pixels_done_nxt = r_pixels_done + 19'd1;
               w_state_nxt       = bus.abort ? S_FLUSH : S_RELEASE;
            end else if (bus.abort) begin
               w_wr_en_nxt = 1'b0;
               w_state_nxt = S_FLUSH;
            end
         end

         S_RELEASE: begin
            if (bus.abort) begin
               w_state_nxt = S_FLUSH;
            end else if (!bus.busy) begin
               if (w_last_pixel) begin
                  w_frame_done_nxt = 1'b1;
                  w_frame_busy_nxt = 1'b0;
                  w_state_nxt      = S_IDLE;
               end else begin
                  if (r_pixel_x == X_LAST) begin
                     w_pixel_x_nxt = '0;
                     w_pixel_y_nxt = r_pixel_y + 10'd1;
                  end else begin
                     w_pixel_x_nxt = r_pixel_x + 10'd1;
                  end
                  w_pixel_valid_nxt = 1'b1;
                  w_state_nxt       = S_WAIT_RESULT;
               end
            end
         end

         S_FLUSH: begin
            if (!bus.busy) begin
               w_frame_busy_nxt = 1'b0;
               w_state_nxt      = S_IDLE;
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of statement or process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_pixel_x     <= '0;
         r_pixel_y     <= '0;
         r_pixel_valid <= 1'b0;
         r_wr_en       <= 1'b0;
         r_wr_x        <= '0;
         r_wr_y        <= '0;
         r_wr_data     <= '0;
         r_frame_busy  <= 1'b0;
         r_frame_done  <= 1'b0;
         r_pixels_done <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_pixel_x     <= w_pixel_x_nxt;
         r_pixel_y     <= w_pixel_y_nxt;
         r_pixel_valid <= w_pixel_valid_nxt;
         r_wr_en       <= w_wr_en_nxt;
         r_wr_x        <= w_wr_x_nxt;
         r_wr_y        <= w_wr_y_nxt;
         r_wr_data     <= w_wr_data_nxt;
         r_frame_busy  <= w_frame_busy_nxt;
         r_frame_done  <= w_frame_done_nxt;
         r_pixels_done <= w_pixels_done_nxt;
      end
   end

   assign bus.pixel_x     = r_pixel_x;
   assign bus.pixel_y     = r_pixel_y;
   assign bus.pixel_valid = r_pixel_valid;
   assign bus.wr_en       = r_wr_en;
   assign bus.wr_x        = r_wr_x;
   assign bus.wr_y        = r_wr_y;
   assign bus.wr_data     = r_wr_data;
   assign bus.frame_busy  = r_frame_busy;
   assign bus.frame_done  = r_frame_done;
   assign bus.pixels_done = r_pixels_done;

endmodule

// File: doc/mandelbrot_pixel_sequencer.md
# mandelbrot_pixel_sequencer

Frame-level scheduler that sits directly upstream of the Mandelbrot engine and downstream of nothing but a start/abort control. It walks every pixel of the frame in raster order, drives the engine's pixel_x/pixel_y/pixel_valid handshake, and captures each iteration_count. Each result is forwarded as a coordinate-tagged write to the framebuffer writer, with backpressure. One engine, one outstanding pixel at a time.

## Interface
- H_PIXELS, 640, pixels per line
- V_PIXELS, 480, lines per frame
- ITER_W, 6, iteration count width; matches the engine
- clk  in  1  system clock; one clock domain, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a frame; honoured only in IDLE
- abort  in  1  single-cycle pulse; cancels the frame in progress
- pixel_x  out  10  engine pixel column
- pixel_y  out  10  engine pixel row
- pixel_valid  out  1  engine request; held until result_valid is seen
- result_valid  in  1  engine result ready; level, held by the engine until pixel_valid drops
- busy  in  1  engine not idle
- iteration_count  in  ITER_W  engine result
- wr_en  out  1  framebuffer write request
- wr_ready  in  1  framebuffer accepts; transfer occurs when wr_en && wr_ready at a rising edge
- wr_x  out  10  write column
- wr_y  out  10  write row
- wr_data  out  ITER_W  iteration count to store
- frame_busy  out  1  high from start until frame_done or abort completes
- frame_done  out  1  one-cycle pulse after the last pixel's write is accepted
- pixels_done  out  19  pixels written this frame; holds its value after the frame ends

## Operation
- All outputs are registered. Reset values: pixel_x = pixel_y = wr_x = wr_y = 0; wr_data = 0; pixels_done = 0; every 1-bit output = 0. State resets to IDLE.
- **IDLE**
  - start: set pixel_x = pixel_y = 0, pixel_valid = 1, pixels_done = 0, frame_busy = 1; go to WAIT_RESULT.
- **WAIT_RESULT**
  - pixel_valid = 1. pixel_x and pixel_y must stay stable, because the engine derives c combinationally from them.
  - result_valid: latch wr_data = iteration_count, wr_x = pixel_x, wr_y = pixel_y; set wr_en = 1, pixel_valid = 0; go to WRITE.
- **WRITE**
  - wr_en stays high and wr_x/wr_y/wr_data stay stable until wr_en && wr_ready.
  - On acceptance: wr_en = 0, pixels_done += 1; go to RELEASE.
- **RELEASE**
  - Wait for busy == 0, i.e. the engine has returned to IDLE.
  - If this was not the last pixel:
    - Advance in raster order: pixel_x + 1, or pixel_x = 0 and pixel_y + 1 when pixel_x == H_PIXELS-1.
    - Set pixel_valid = 1; go to WAIT_RESULT.
  - Last pixel (pixel_x == H_PIXELS-1 and pixel_y == V_PIXELS-1): frame_done = 1 for one cycle, frame_busy = 0; go to IDLE.
- **FLUSH** (abort path)
  - abort in any non-IDLE state: pixel_valid = 0, wr_en = 0, go to FLUSH.
  - FLUSH waits for busy == 0, then sets frame_busy = 0 and goes to IDLE.
  - No frame_done pulse on abort. pixels_done holds the count reached.
- Boundary rules:
  - start while not in IDLE: ignored.
  - start and abort in the same IDLE cycle: abort wins; stay in IDLE.
  - abort in the same cycle as a WRITE acceptance: the write counts (pixels_done increments), then go to FLUSH.
  - abort in IDLE: no effect.
  - Engine enable low: the engine stalls; the sequencer simply waits. There is no timeout.
  - Reset mid-frame: immediate return to reset values, regardless of engine state.

## Timing
- start sampled at edge N: pixel_valid = 1 with coordinates (0,0) from edge N.
- result_valid sampled at edge M: wr_en = 1 and pixel_valid = 0 from edge M.
- The engine sees pixel_valid low at M+1 and clears busy after M+1.
- With wr_ready = 1 and the engine enabled:
  - Write accepted at M+1.
  - busy == 0 seen at M+2; next pixel_valid = 1 from M+2.
  - Fixed overhead per pixel: 3 cycles beyond engine compute time.
- Last pixel with wr_ready = 1: frame_done pulses in the cycle after the busy == 0 edge.
- Never more than one pixel outstanding. wr_en is never asserted while pixel_valid is high.

## Test plan
- Engine model with 5-cycle compute returning iteration_count = (x+y)%64; H_PIXELS=4, V_PIXELS=3 -> 12 writes in raster order (0,0)…(3,2), wr_data correct, pixels_done = 12, a single frame_done pulse, frame_busy low afterwards.
- Same run with wr_ready low for 7 cycles on pixel (2,1) -> wr_en, wr_x/wr_y/wr_data stable throughout the stall, no new pixel_valid, a single write for that pixel.
- Engine holds busy high 4 cycles after pixel_valid drops -> no advance until busy == 0; next pixel_valid at the edge busy is seen low.
- abort during WAIT_RESULT of pixel (1,1) (5 writes done) -> pixel_valid = 0 next edge, FLUSH until busy = 0, IDLE, no frame_done, pixels_done = 5; a following start restarts at (0,0).
- start pulsed mid-frame, then start+abort together in IDLE -> both ignored, frame unaffected, sequencer stays in IDLE.
- rst_n asserted mid-WRITE -> all outputs return to reset values asynchronously; after release the sequencer stays in IDLE until start.
